// File: rtl/hub75_capture.sv
// ---------------------------------------------------------------------------
// hub75_capture
//
// Passive HUB75 panel-bus sniffer. Samples the panel signals on the system
// clock, rebuilds each shifted row pair into a double-buffered line store and
// drains the finished row pair as a stream of pixel writes (upper row first,
// then lower row) over a valid/ready handshake.
//
// Optional feature macro: HUB75_CAPTURE_SYNC_EN
//   defined   : two synchronizer flops per panel input ahead of the sample
//               stage (asynchronous panel source), pix_valid 4 edges after lat
//   undefined : panel inputs sampled directly (same-clock source),
//               pix_valid 2 edges after lat
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   r1,g1,b1 / r2,g2,b2     upper-half / lower-half colour bits
//   abcde[4:0]              row address
//   clk, lat, oe            panel shift clock, latch, output enable (active low)
//   pix_valid / pix_ready   pixel-write handshake
//   pix_x, pix_y [5:0]      pixel column / row
//   pix_rgb[2:0]            {b,g,r} of the pixel
//   row_done                one-cycle pulse after the last lower-row transfer
//   on_cycles[15:0]         oe-low cycles in the last completed row period
//   err_width, err_overrun  sticky: too many shift clocks / latch while busy
// ---------------------------------------------------------------------------
module hub75_capture #(
    parameter int k_width  = 64,
    parameter int k_height = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        r1,
    input  logic        g1,
    input  logic        b1,
    input  logic        r2,
    input  logic        g2,
    input  logic        b2,
    input  logic [4:0]  abcde,
    input  logic        clk,
    input  logic        lat,
    input  logic        oe,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [5:0]  pix_x,
    output logic [5:0]  pix_y,
    output logic [2:0]  pix_rgb,
    output logic        row_done,
    output logic [15:0] on_cycles,
    output logic        err_width,
    output logic        err_overrun
);

    localparam int AW = (k_width > 1) ? $clog2(k_width) : 1;
    localparam int NW = $clog2(k_width + 1);
    localparam int PW = 14;
    localparam logic [5:0] HALF_ROWS = 6'(k_height / 2);

    typedef enum logic [1:0] {IDLE, UPPER, LOWER} state_t;

    // ---------------- input sampling ----------------
    logic [PW-1:0] pin_bus;
    logic [PW-1:0] sample_d, sample_q;

    assign pin_bus = {r1, g1, b1, r2, g2, b2, abcde, clk, lat, oe};

`ifdef HUB75_CAPTURE_SYNC_EN
    logic [PW-1:0] sync1_q, sync2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pin_bus;
            sync2_q <= sync1_q;
        end
    end

    assign sample_d = sync2_q;
`else
    assign sample_d = pin_bus;
`endif

    logic       s_clk, s_lat, s_oe;
    logic [4:0] s_abcde;
    logic [5:0] cap_word;

    assign s_oe    = sample_q[0];
    assign s_lat   = sample_q[1];
    assign s_clk   = sample_q[2];
    assign s_abcde = sample_q[7:3];
    // Stored column word: {b2,g2,r2,b1,g1,r1}; low half is the upper-row pixel.
    assign cap_word = {sample_q[8], sample_q[9], sample_q[10],
                       sample_q[11], sample_q[12], sample_q[13]};

    // ---------------- state ----------------
    state_t          state_d, state_q;
    logic [AW-1:0]   x_d, x_q;
    logic [5:0]      y_d, y_q;
    logic [4:0]      row_d, row_q;
    logic            valid_d, valid_q;
    logic            row_done_d, row_done_q;
    logic            cap_bank_d, cap_bank_q;
    logic [NW-1:0]   n_d, n_q;
    logic            err_width_d, err_width_q;
    logic            err_overrun_d, err_overrun_q;
    logic [15:0]     oe_cnt_d, oe_cnt_q;
    logic [15:0]     on_cycles_d, on_cycles_q;
    logic            clk_prev_d, clk_prev_q;
    logic            lat_prev_d, lat_prev_q;

    logic            clk_rise, lat_rise, xfer, x_last, accept, wr_en;
    logic [AW-1:0]   wr_col;
    logic [5:0]      drain_word;

    // Two line buffers; the capture side writes one while the drain reads the other.
    logic [5:0] bank_mem [0:1][0:k_width-1];

    assign clk_rise = s_clk & ~clk_prev_q;
    assign lat_rise = s_lat & ~lat_prev_q;
    assign xfer     = valid_q & pix_ready;
    assign x_last   = (x_q == AW'(k_width - 1));
    // A latch landing on the final lower transfer chains straight into the next row.
    assign accept   = lat_rise & ((state_q == IDLE) |
                                  ((state_q == LOWER) & xfer & x_last));
    assign wr_en    = clk_rise & (n_q < NW'(k_width));
    // First shifted column ends up furthest from the panel input.
    assign wr_col   = AW'(k_width - 1) - n_q[AW-1:0];

    // The write uses the pre-swap bank, so a clk edge coincident with lat
    // still lands in the row that is about to be drained.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            bank_mem[cap_bank_q][wr_col] <= cap_word;
        end
    end

    assign drain_word = bank_mem[~cap_bank_q][x_q];

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        row_d         = row_q;
        valid_d       = valid_q;
        row_done_d    = 1'b0;
        cap_bank_d    = cap_bank_q;
        n_d           = n_q;
        err_width_d   = err_width_q;
        err_overrun_d = err_overrun_q;
        oe_cnt_d      = oe_cnt_q;
        on_cycles_d   = on_cycles_q;
        clk_prev_d    = s_clk;
        lat_prev_d    = s_lat;

        // capture column counter
        if (clk_rise && !wr_en) begin
            err_width_d = 1'b1;
        end
        if (wr_en) begin
            n_d = n_q + NW'(1);
        end
        if (lat_rise) begin
            n_d = '0;
        end

        // output-enable duty measurement per row period
        if (lat_rise) begin
            on_cycles_d = oe_cnt_q;
            oe_cnt_d    = '0;
        end else if (!s_oe && (oe_cnt_q != 16'hFFFF)) begin
            oe_cnt_d = oe_cnt_q + 16'd1;
        end

        // drain sequencing
        case (state_q)
            UPPER: begin
                if (xfer) begin
                    if (x_last) begin
                        state_d = LOWER;
                        x_d     = '0;
                        y_d     = {1'b0, row_q} + HALF_ROWS;
                    end else begin
                        x_d = x_q + AW'(1);
                    end
                end
            end
            LOWER: begin
                if (xfer) begin
                    if (x_last) begin
                        state_d    = IDLE;
                        valid_d    = 1'b0;
                        row_done_d = 1'b1;
                    end else begin
                        x_d = x_q + AW'(1);
                    end
                end
            end
            default: ;
        endcase

        // An overrun latch leaves banks and row address alone so the
        // in-flight drain is never corrupted; that row is simply lost.
        if (accept) begin
            state_d    = UPPER;
            x_d        = '0;
            row_d      = s_abcde;
            y_d        = {1'b0, s_abcde};
            valid_d    = 1'b1;
            cap_bank_d = ~cap_bank_q;
        end else if (lat_rise) begin
            err_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sample_q      <= '0;
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            row_q         <= '0;
            valid_q       <= 1'b0;
            row_done_q    <= 1'b0;
            cap_bank_q    <= 1'b0;
            n_q           <= '0;
            err_width_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            oe_cnt_q      <= '0;
            on_cycles_q   <= '0;
            clk_prev_q    <= 1'b0;
            lat_prev_q    <= 1'b0;
        end else begin
            sample_q      <= sample_d;
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            row_q         <= row_d;
            valid_q       <= valid_d;
            row_done_q    <= row_done_d;
            cap_bank_q    <= cap_bank_d;
            n_q           <= n_d;
            err_width_q   <= err_width_d;
            err_overrun_q <= err_overrun_d;
            oe_cnt_q      <= oe_cnt_d;
            on_cycles_q   <= on_cycles_d;
            clk_prev_q    <= clk_prev_d;
            lat_prev_q    <= lat_prev_d;
        end
    end

    assign pix_valid   = valid_q;
    assign pix_x       = 6'(x_q);
    assign pix_y       = y_q;
    assign pix_rgb     = (state_q == LOWER) ? drain_word[5:3] : drain_word[2:0];
    assign row_done    = row_done_q;
    assign on_cycles   = on_cycles_q;
    assign err_width   = err_width_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_hub75_capture.sv
// ---------------------------------------------------------------------------
// tb_hub75_capture
//
// Directed bench for hub75_capture (default build, 64x64). Table of row
// vectors (row address, pulse count, data seed, ready pattern, expected
// err_width) plus hand-written sequences for back-to-back latching, oe duty
// measurement, overrun with latency and reset mid-drain.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hub75_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic        r1, g1, b1, r2, g2, b2;
    logic [4:0]  abcde;
    logic        sclk, lat, oe;
    logic        pix_valid;
    logic        pix_ready;
    logic [5:0]  pix_x, pix_y;
    logic [2:0]  pix_rgb;
    logic        row_done;
    logic [15:0] on_cycles;
    logic        err_width, err_overrun;

    always #5 clock = ~clock;

    hub75_capture dut (
        .clock       (clock),
        .reset       (reset),
        .r1          (r1),
        .g1          (g1),
        .b1          (b1),
        .r2          (r2),
        .g2          (g2),
        .b2          (b2),
        .abcde       (abcde),
        .clk         (sclk),
        .lat         (lat),
        .oe          (oe),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .row_done    (row_done),
        .on_cycles   (on_cycles),
        .err_width   (err_width),
        .err_overrun (err_overrun)
    );

    typedef struct packed {
        logic [5:0] x;
        logic [5:0] y;
        logic [2:0] rgb;
    } pix_t;

    typedef struct {
        logic [4:0] row;
        int         pulses;
        int         seed;
        bit         rand_ready;
        bit         exp_err_width;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   rd_cnt = 0;
    int   gap_cnt = 0;
    bit   armed = 1'b0;
    pix_t got_q[$];
    logic [5:0] wa [64];
    logic [5:0] wb [64];

    bit   prev_stall = 1'b0;
    pix_t prev_pix;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor: transfers, row_done pulses, no-gap window, stall stability.
    always @(negedge clock) begin
        pix_t cur;
        cur = '{x: pix_x, y: pix_y, rgb: pix_rgb};
        if (row_done === 1'b1) rd_cnt++;
        if (armed && pix_valid !== 1'b1 && row_done !== 1'b1) gap_cnt++;
        if (prev_stall) begin
            chk("stall_valid", 32'(pix_valid), 32'd1);
            chk("stall_hold", 32'(cur), 32'(prev_pix));
        end
        prev_stall = (pix_valid === 1'b1) && (pix_ready === 1'b0) && (reset === 1'b0);
        prev_pix   = cur;
        if (pix_valid === 1'b1 && pix_ready === 1'b1 && reset === 1'b0)
            got_q.push_back(cur);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input logic [5:0] w);
        {r1, g1, b1, r2, g2, b2} = w;
        sclk = 1'b1;
        tick();
        sclk = 1'b0;
        tick();
    endtask

    task automatic latch(input logic [4:0] row);
        abcde = row;
        lat   = 1'b1;
        tick();
        lat   = 1'b0;
        tick();
    endtask

    task automatic wait_rows(input int target, input bit rnd);
        int cyc;
        cyc = 0;
        while (rd_cnt < target && cyc < 4000) begin
            if (rnd) pix_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        pix_ready = 1'b1;
        chk("drain_done_in_budget", 32'(rd_cnt >= target), 32'd1);
    endtask

    function automatic logic [5:0] pat(input int seed, input int i);
        if (seed == 0) return (i % 2 == 1) ? 6'b100000 : 6'b000000;
        return 6'((i * 7 + seed * 13) ^ (i >> 2) ^ (seed << 3));
    endfunction

    // Column x holds the data of pulse 63-x; upper row takes {b1,g1,r1}.
    task automatic check_row(input int base, input logic [4:0] row, input bit sel);
        for (int i = 0; i < 128; i++) begin
            int         x;
            logic [5:0] w;
            pix_t       e;
            x = i % 64;
            w = sel ? wb[63 - x] : wa[63 - x];
            e.x   = 6'(x);
            e.y   = (i < 64) ? {1'b0, row} : ({1'b0, row} + 6'd32);
            e.rgb = (i < 64) ? {w[3], w[4], w[5]} : {w[0], w[1], w[2]};
            if (base + i < got_q.size())
                chk($sformatf("pix[%0d]", base + i), 32'(got_q[base + i]), 32'(e));
        end
    endtask

    vec_t vecs [4];

    initial begin
        int start;

        vecs[0] = '{row: 5'd0,  pulses: 64, seed: 0, rand_ready: 1'b0, exp_err_width: 1'b0};
        vecs[1] = '{row: 5'd5,  pulses: 64, seed: 1, rand_ready: 1'b0, exp_err_width: 1'b0};
        vecs[2] = '{row: 5'd31, pulses: 64, seed: 2, rand_ready: 1'b1, exp_err_width: 1'b0};
        vecs[3] = '{row: 5'd17, pulses: 65, seed: 3, rand_ready: 1'b0, exp_err_width: 1'b1};

        reset = 1'b1;
        {r1, g1, b1, r2, g2, b2} = '0;
        abcde = '0;
        sclk = 1'b0;
        lat = 1'b0;
        oe = 1'b1;
        pix_ready = 1'b1;
        repeat (3) tick();
        chk("reset_pix_valid", 32'(pix_valid), 32'd0);
        chk("reset_row_done", 32'(row_done), 32'd0);
        chk("reset_err_width", 32'(err_width), 32'd0);
        chk("reset_err_overrun", 32'(err_overrun), 32'd0);
        chk("reset_on_cycles", 32'(on_cycles), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // ---------------- table-driven rows ----------------
        for (int v = 0; v < 4; v++) begin
            got_q.delete();
            start = rd_cnt;
            for (int i = 0; i < vecs[v].pulses; i++) begin
                if (i < 64) wa[i] = pat(vecs[v].seed, i);
                pulse(pat(vecs[v].seed, i));
            end
            latch(vecs[v].row);
            wait_rows(start + 1, vecs[v].rand_ready);
            repeat (3) tick();
            chk($sformatf("vec%0d_row_done_once", v), 32'(rd_cnt - start), 32'd1);
            chk($sformatf("vec%0d_xfer_count", v), 32'(got_q.size()), 32'd128);
            check_row(0, vecs[v].row, 1'b0);
            chk($sformatf("vec%0d_err_width", v), 32'(err_width), 32'(vecs[v].exp_err_width));
            $display("row vec=%0d abcde=%0d pulses=%0d xfers=%0d err_width=%0b errors=%0d",
                     v, vecs[v].row, vecs[v].pulses, got_q.size(), err_width, errors);
        end

        // ---------------- back-to-back latch on final transfer ----------------
        got_q.delete();
        start = rd_cnt;
        pix_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            wa[i] = pat(5, i);
            pulse(wa[i]);
        end
        for (int i = 0; i < 64; i++) wb[i] = pat(6, i);
        latch(5'd12);
        gap_cnt = 0;
        armed = 1'b1;
        for (int i = 0; i < 63; i++) pulse(wb[i]);
        // lat and the 64th clk share one sample, timed onto the last LOWER transfer
        {r1, g1, b1, r2, g2, b2} = wb[63];
        abcde = 5'd20;
        sclk = 1'b1;
        lat = 1'b1;
        tick();
        sclk = 1'b0;
        lat = 1'b0;
        tick();
        wait_rows(start + 2, 1'b0);
        armed = 1'b0;
        repeat (3) tick();
        chk("b2b_row_done_twice", 32'(rd_cnt - start), 32'd2);
        chk("b2b_no_idle_gap", 32'(gap_cnt), 32'd0);
        chk("b2b_no_overrun", 32'(err_overrun), 32'd0);
        chk("b2b_xfer_count", 32'(got_q.size()), 32'd256);
        check_row(0, 5'd12, 1'b0);
        check_row(128, 5'd20, 1'b1);
        $display("back_to_back rows=12,20 xfers=%0d gaps=%0d errors=%0d", got_q.size(), gap_cnt, errors);

        // ---------------- on_cycles measurement ----------------
        start = rd_cnt;
        latch(5'd3);
        chk("on_cycles_zero", 32'(on_cycles), 32'd0);
        wait_rows(start + 1, 1'b0);
        oe = 1'b0;
        repeat (100) tick();
        oe = 1'b1;
        repeat (2) tick();
        latch(5'd4);
        chk("on_cycles_100", 32'(on_cycles), 32'd100);
        wait_rows(start + 2, 1'b0);
        $display("on_cycles measured=%0d errors=%0d", on_cycles, errors);

        // ---------------- latency + overrun during stalled UPPER ----------------
        got_q.delete();
        start = rd_cnt;
        for (int i = 0; i < 64; i++) begin
            wa[i] = pat(9, i);
            pulse(wa[i]);
        end
        pix_ready = 1'b0;
        abcde = 5'd9;
        lat = 1'b1;
        tick();
        chk("latency_edge1_valid", 32'(pix_valid), 32'd0);
        lat = 1'b0;
        tick();
        chk("latency_edge2_valid", 32'(pix_valid), 32'd1);
        chk("overrun_pre_flag", 32'(err_overrun), 32'd0);
        for (int i = 0; i < 64; i++) pulse(pat(10, i));
        latch(5'd10);
        repeat (2) tick();
        chk("overrun_flag", 32'(err_overrun), 32'd1);
        chk("overrun_keep_y", 32'(pix_y), 32'd9);
        chk("overrun_keep_x", 32'(pix_x), 32'd0);
        pix_ready = 1'b1;
        wait_rows(start + 1, 1'b0);
        repeat (3) tick();
        chk("overrun_row_done_once", 32'(rd_cnt - start), 32'd1);
        chk("overrun_xfer_count", 32'(got_q.size()), 32'd128);
        check_row(0, 5'd9, 1'b0);
        $display("overrun row=9 xfers=%0d err_overrun=%0b errors=%0d", got_q.size(), err_overrun, errors);

        // ---------------- reset mid-drain ----------------
        start = rd_cnt;
        pix_ready = 1'b0;
        latch(5'd7);
        chk("mid_reset_pre_valid", 32'(pix_valid), 32'd1);
        pix_ready = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("mid_reset_valid", 32'(pix_valid), 32'd0);
        reset = 1'b0;
        repeat (10) tick();
        chk("mid_reset_no_row_done", 32'(rd_cnt - start), 32'd0);
        chk("mid_reset_valid_idle", 32'(pix_valid), 32'd0);
        chk("mid_reset_err_overrun", 32'(err_overrun), 32'd0);
        chk("mid_reset_err_width", 32'(err_width), 32'd0);
        $display("reset_mid_drain row_done_delta=%0d pix_valid=%0b errors=%0d",
                 rd_cnt - start, pix_valid, errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hub75_capture.md
HUB75_CAPTURE -- requirements
Module: hub75_capture

Interface
REQ-001 SHALL have parameter k_width, default 64, meaning panel columns per row (shift-register length).
REQ-002 SHALL have parameter k_height, default 64, meaning panel rows; the row-address space is k_height/2.
REQ-003 SHALL have port clock  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports r1, g1, b1, r2, g2, b2  in  1 each  upper-half and lower-half colour bits.
REQ-006 SHALL have port abcde  in  5  row address.
REQ-007 SHALL have ports clk, lat, oe  in  1 each  panel shift clock, latch, output enable (active-low).
REQ-008 SHALL have port pix_valid  out  1  pixel-write valid.
REQ-009 SHALL have port pix_ready  in  1  pixel-write ready.
REQ-010 SHALL have ports pix_x and pix_y  out  6 each  pixel column and row.
REQ-011 SHALL have port pix_rgb  out  3  {b,g,r} of the pixel.
REQ-012 SHALL have port row_done  out  1  one-cycle pulse when a row pair finishes draining.
REQ-013 SHALL have port on_cycles  out  16  clock cycles with oe low in the last completed row period.
REQ-014 SHALL have ports err_width and err_overrun  out  1 each  sticky error flags.

Function
REQ-015 SHALL register all panel inputs in one sample stage; edges are detected against the previous sample.
REQ-016 SHALL, on each clk rising edge, write {r1,g1,b1} and {r2,g2,b2} into the capture bank at column k_width-1-n, n being the count of edges since the last latch.
REQ-017 SHALL ignore clk edges once n reaches k_width, and SHALL set err_width.
REQ-018 SHALL, on a lat rising edge, capture abcde, reset n to 0, and swap the capture and drain banks (two k_width x 6-bit buffers).
REQ-019 SHALL, if clk and lat rise in the same sample, store the clk data in the pre-swap bank before swapping.
REQ-020 SHALL run a drain FSM with states IDLE, UPPER, and LOWER; a latch accepted in IDLE enters UPPER.
REQ-021 SHALL emit in UPPER x=0..k_width-1 with pix_y=abcde, then in LOWER x=0..k_width-1 with pix_y=abcde+k_height/2.
REQ-022 SHALL hold pix_valid, pix_x, pix_y, and pix_rgb stable until a transfer occurs (pix_valid && pix_ready).
REQ-023 SHALL, after the last LOWER transfer, pulse row_done for one cycle and return to IDLE.
REQ-024 SHALL, on a latch arriving while the FSM is not IDLE, set err_overrun, drop that row, and leave the drain uninterrupted.
REQ-025 SHALL accept (not overrun) a latch arriving in the same cycle as the final LOWER transfer, re-entering UPPER with no idle cycle.
REQ-026 SHALL assert pix_valid on the second clock edge after lat goes high at the pin.
REQ-027 SHALL count sampled cycles with oe low, saturating at 16'hFFFF, and load the count into on_cycles at each lat rising edge, then clear the counter.

Reset
REQ-028 SHALL, in reset, set pix_valid, row_done, err_width, err_overrun, on_cycles, n, and the oe counter to 0, the FSM to IDLE, and sample registers to 0.
REQ-029 SHALL, on reset mid-drain, abandon the row with no row_done; buffer contents need not be cleared.

Configuration
REQ-030 SHALL, with HUB75_CAPTURE_SYNC_EN defined, insert two synchronizer flops per panel input ahead of the sample stage; pix_valid latency becomes 4 edges.
REQ-031 SHALL, without HUB75_CAPTURE_SYNC_EN, use inputs directly (same-clock source), with a latency of 2 edges.

Verification
REQ-032 SHALL cover: 64 clk pulses (data = col index parity on r1), lat, pix_ready=1 -> 128 transfers, x 0..63, correct parity mapping reversed, row_done once.
REQ-033 SHALL cover: abcde=5 latched -> UPPER pix_y=5, LOWER pix_y=37.
REQ-034 SHALL cover: 65 clk pulses -> err_width=1; first-shifted pixel lands at x=63.
REQ-035 SHALL cover: second lat during UPPER with pix_ready=0 -> err_overrun=1, drain still completes the first row.
REQ-036 SHALL cover: pix_ready toggled randomly -> outputs stable while stalled, no pixel lost or duplicated.
REQ-037 SHALL cover: oe low for 100 cycles between latches -> on_cycles=100; reset mid-drain -> pix_valid=0 next cycle, no row_done.
